// File: rtl/comp_mult_arbiter_pkg.sv
// Shared definitions for the complex-multiplier arbiter.
// Provides default parameter values, derived-width helpers and the slice
// helper used to pick one requester's operand bundle out of the packed bus.
package comp_mult_arbiter_pkg;

    localparam int DEF_DWIDTH    = 8;
    localparam int DEF_NO_REQ    = 4;
    localparam int DEF_TAG_DEPTH = 4;

    // Operand bundle {x1,y1,x2,y2}.
    function automatic int op_width(input int dwidth);
        return 4 * dwidth;
    endfunction

    // Result bundle {xr,yr}.
    function automatic int res_width(input int dwidth);
        return 4 * (dwidth + 1);
    endfunction

    // Requester index width; never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB of requester idx's slice in a packed per-requester bus.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/comp_mult_tag_fifo.sv
// Synchronous FIFO holding the requester index of every operation that is
// in flight inside the multiplier.
// Ports:
//   clk, rst_n (async, active low), sw_rst (sync clear, active high)
//   push / wdata : enqueue (ignored while full)
//   pop  / rdata : dequeue (ignored while empty); rdata is the current head
//   full, empty, count : occupancy, all derived from registered count
module comp_mult_tag_fifo
    import comp_mult_arbiter_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = DEF_TAG_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sw_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap on natural overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (sw_rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/comp_mult_arbiter.sv
// Shares one in-order complex multiplier between NO_REQ requesters.
// Operand requests are arbitrated round-robin with zero added latency; the
// requester index of each accepted operation is queued so every result is
// routed back to the requester that issued it.
// Ports:
//   clk, rst_n (async, active low), sw_rst (sync clear, active high)
//   req_op_val/rdy/data   : per-requester operand channels (packed, slice i = requester i)
//   req_res_val/rdy       : per-requester result handshake; req_res_data is broadcast
//   mult_op_val/rdy/data  : operand channel to the multiplier
//   mult_res_val/rdy/data : result channel from the multiplier
//   busy       : at least one operation outstanding
//   err_orphan : sticky, a result arrived while nothing was outstanding
module comp_mult_arbiter
    import comp_mult_arbiter_pkg::*;
#(
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int NO_REQ    = DEF_NO_REQ,
    parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sw_rst,
    input  logic [NO_REQ-1:0]            req_op_val,
    output logic [NO_REQ-1:0]            req_op_rdy,
    input  logic [NO_REQ*4*DWIDTH-1:0]   req_op_data,
    output logic [NO_REQ-1:0]            req_res_val,
    input  logic [NO_REQ-1:0]            req_res_rdy,
    output logic [4*(DWIDTH+1)-1:0]      req_res_data,
    output logic                         mult_op_val,
    input  logic                         mult_op_rdy,
    output logic [4*DWIDTH-1:0]          mult_op_data,
    input  logic                         mult_res_val,
    output logic                         mult_res_rdy,
    input  logic [4*(DWIDTH+1)-1:0]      mult_res_data,
    output logic                         busy,
    output logic                         err_orphan
);

    localparam int OP_W  = op_width(DWIDTH);
    localparam int IDX_W = idx_width(NO_REQ);
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_REQ - 1);

    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             lock_q, lock_d;
    logic             err_orphan_q, err_orphan_d;
    logic [IDX_W-1:0] grant, head;
    logic             tag_full, tag_empty, op_accept, res_accept;
    logic [CNT_W-1:0] tag_count;

    // Round-robin search starting one past the last accepted index. While
    // locked, the stalled grant is held so mult_op_data cannot change under
    // a pending handshake.
    always_comb begin : arbitrate
        logic             found;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        cand  = '0;
        grant = lock_q ? lock_idx_q : rr_q;
        if (!lock_q) begin
            for (int k = 1; k <= NO_REQ; k++) begin
                cand = IDX_W'((int'(rr_q) + k) % NO_REQ);
                if (!found && req_op_val[cand]) begin
                    grant = cand;
                    found = 1'b1;
                end
            end
        end
    end

    // Operand path: pure routing, no added latency.
    assign mult_op_val  = (|req_op_val) & ~tag_full;
    assign op_accept    = mult_op_val & mult_op_rdy;
    assign mult_op_data = req_op_data[slice_lsb(int'(grant), OP_W) +: OP_W];

    always_comb begin
        req_op_rdy        = '0;
        req_op_rdy[grant] = op_accept;
    end

    // Result path: the FIFO head names the issuer of the oldest operation.
    // With nothing outstanding, results are orphans and are swallowed.
    always_comb begin
        req_res_val       = '0;
        req_res_val[head] = mult_res_val & ~tag_empty;
        mult_res_rdy      = tag_empty ? 1'b1 : req_res_rdy[head];
    end

    assign res_accept   = mult_res_val & mult_res_rdy & ~tag_empty;
    assign req_res_data = mult_res_data;
    assign busy         = (tag_count != '0);
    assign err_orphan   = err_orphan_q;

    always_comb begin
        lock_d       = lock_q;
        lock_idx_d   = lock_idx_q;
        rr_d         = rr_q;
        err_orphan_d = err_orphan_q;
        if (op_accept) begin
            lock_d = 1'b0;
            rr_d   = grant;
        end else if (mult_op_val) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
        if (mult_res_val && tag_empty) err_orphan_d = 1'b1;
        if (sw_rst) begin
            lock_d       = 1'b0;
            lock_idx_d   = '0;
            rr_d         = LAST_IDX;
            err_orphan_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            rr_q         <= LAST_IDX;
            err_orphan_q <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            rr_q         <= rr_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    comp_mult_tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_rst (sw_rst),
        .push   (op_accept),
        .pop    (res_accept),
        .wdata  (grant),
        .rdata  (head),
        .full   (tag_full),
        .empty  (tag_empty),
        .count  (tag_count)
    );

endmodule

// File: tb/tb_comp_mult_arbiter.sv
// Self-checking bench for comp_mult_arbiter. The bench plays all requesters
// and an in-order multiplier stub; a reference model (queue of outstanding
// operations in acceptance order, complex products computed arithmetically)
// predicts every handshake and value.
`timescale 1ns/1ps
module tb_comp_mult_arbiter;

    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int TD    = 4;
    localparam int OPW   = 4 * DW;
    localparam int CW    = 2 * (DW + 1);
    localparam int RESW  = 4 * (DW + 1);
    localparam int N_OPS = 1000;

    logic               clk;
    logic               rst_n;
    logic               sw_rst;
    logic [NR-1:0]      req_op_val;
    logic [NR-1:0]      req_op_rdy;
    logic [NR*OPW-1:0]  req_op_data;
    logic [NR-1:0]      req_res_val;
    logic [NR-1:0]      req_res_rdy;
    logic [RESW-1:0]    req_res_data;
    logic               mult_op_val;
    logic               mult_op_rdy;
    logic [OPW-1:0]     mult_op_data;
    logic               mult_res_val;
    logic               mult_res_rdy;
    logic [RESW-1:0]    mult_res_data;
    logic               busy;
    logic               err_orphan;

    comp_mult_arbiter #(
        .DWIDTH    (DW),
        .NO_REQ    (NR),
        .TAG_DEPTH (TD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw_rst        (sw_rst),
        .req_op_val    (req_op_val),
        .req_op_rdy    (req_op_rdy),
        .req_op_data   (req_op_data),
        .req_res_val   (req_res_val),
        .req_res_rdy   (req_res_rdy),
        .req_res_data  (req_res_data),
        .mult_op_val   (mult_op_val),
        .mult_op_rdy   (mult_op_rdy),
        .mult_op_data  (mult_op_data),
        .mult_res_val  (mult_res_val),
        .mult_res_rdy  (mult_res_rdy),
        .mult_res_data (mult_res_data),
        .busy          (busy),
        .err_orphan    (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              idx;
        logic [RESW-1:0] res;
    } exp_t;

    exp_t            exp_q[$];     // outstanding ops, oldest first
    logic [OPW-1:0]  stub_q[$];    // operands inside the multiplier stub
    int              grant_log[$];
    int              deliv_idx[$];
    logic [RESW-1:0] deliv_res[$];

    logic [OPW-1:0]  rq_data [NR];
    bit              rq_pend [NR];
    int              wait_acc [NR];

    bit              stub_val;
    bit              stub_orphan;
    logic [RESW-1:0] stub_data;
    bit              exp_orphan;
    bit              prev_op_stall;
    logic [OPW-1:0]  prev_op_data;

    bit              auto_req;
    int              p_new, p_op_rdy, p_res_rdy, p_res_val;
    int              n_cmp, n_fail, total_acc;

    // (x1 + i*y1) * (x2 + i*y2), operands signed.
    function automatic logic [RESW-1:0] cmul(input logic [OPW-1:0] op);
        int x1, y1, x2, y2, xr, yr;
        x1 = $signed(op[OPW-1 -: DW]);
        y1 = $signed(op[3*DW-1 -: DW]);
        x2 = $signed(op[2*DW-1 -: DW]);
        y2 = $signed(op[DW-1:0]);
        xr = x1 * x2 - y1 * y2;
        yr = x1 * y2 + y1 * x2;
        return {CW'(xr), CW'(yr)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input int r, input logic [OPW-1:0] data);
        rq_pend[r]  = 1'b1;
        rq_data[r]  = data;
        wait_acc[r] = 0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        stub_q.delete();
        stub_val      = 1'b0;
        stub_orphan   = 1'b0;
        exp_orphan    = 1'b0;
        prev_op_stall = 1'b0;
        mult_res_val  = 1'b0;
        for (int r = 0; r < NR; r++) wait_acc[r] = 0;
    endtask

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            if (auto_req && !rq_pend[r] && $urandom_range(99) < p_new)
                arm(r, OPW'($urandom));
            req_op_val[r]               = rq_pend[r];
            req_op_data[r*OPW +: OPW]   = rq_data[r];
            req_res_rdy[r]              = ($urandom_range(99) < p_res_rdy);
        end
        mult_op_rdy = ($urandom_range(99) < p_op_rdy);
        if (!stub_val && stub_q.size() > 0 && $urandom_range(99) < p_res_val) begin
            stub_val  = 1'b1;
            stub_data = cmul(stub_q[0]);
        end
        mult_res_val  = stub_val;
        mult_res_data = stub_data;
    endtask

    // One clock: drive at negedge, check settled outputs, update model at posedge.
    task automatic run_cycle();
        bit             acc, res_hs, orphan_now, stall, srst;
        int             g, head;
        logic [OPW-1:0] cur_op_data;
        drive();
        #1;
        check("mult_op_val", 64'(mult_op_val), 64'((|req_op_val) && exp_q.size() < TD));
        check("busy", 64'(busy), 64'(exp_q.size() != 0));
        check("err_orphan", 64'(err_orphan), 64'(exp_orphan));
        if (prev_op_stall) check("op_hold", 64'(mult_op_data), 64'(prev_op_data));
        acc = mult_op_val && mult_op_rdy;
        g   = -1;
        if (acc) begin
            check("op_rdy_onehot", 64'($countones(req_op_rdy)), 64'(1));
            for (int r = 0; r < NR; r++) if (req_op_rdy[r]) g = r;
            if (g >= 0) begin
                check("op_rdy_valid", 64'(req_op_val[g]), 64'(1));
                check("op_data", 64'(mult_op_data), 64'(rq_data[g]));
            end
        end else begin
            check("op_rdy_idle", 64'(req_op_rdy), 64'(0));
        end
        res_hs     = 1'b0;
        orphan_now = 1'b0;
        head       = -1;
        if (mult_res_val) begin
            res_hs = mult_res_rdy;
            if (exp_q.size() == 0) begin
                orphan_now = 1'b1;
                check("orphan_rdy", 64'(mult_res_rdy), 64'(1));
                check("orphan_val", 64'(req_res_val), 64'(0));
            end else begin
                head = exp_q[0].idx;
                check("res_val", 64'(req_res_val), 64'(1) << head);
                check("res_rdy", 64'(mult_res_rdy), 64'(req_res_rdy[head]));
                check("res_data", 64'(req_res_data), 64'(exp_q[0].res));
            end
        end else begin
            check("res_idle", 64'(req_res_val), 64'(0));
        end
        stall       = mult_op_val && !mult_op_rdy;
        cur_op_data = mult_op_data;
        srst        = sw_rst;
        @(posedge clk);
        if (res_hs) begin
            if (stub_orphan) stub_orphan = 1'b0;
            else if (stub_q.size() > 0) void'(stub_q.pop_front());
            stub_val = 1'b0;
            if (!orphan_now) begin
                deliv_idx.push_back(head);
                deliv_res.push_back(exp_q[0].res);
                void'(exp_q.pop_front());
            end
        end
        if (orphan_now) exp_orphan = 1'b1;
        if (acc && g >= 0) begin
            for (int r = 0; r < NR; r++) if (r != g && rq_pend[r]) wait_acc[r]++;
            check("fairness", 64'(wait_acc[g] < NR), 64'(1));
            exp_q.push_back('{idx: g, res: cmul(rq_data[g])});
            stub_q.push_back(rq_data[g]);
            grant_log.push_back(g);
            total_acc++;
            rq_pend[g] = 1'b0;
        end
        prev_op_stall = stall;
        prev_op_data  = cur_op_data;
        if (srst) model_reset();
        @(negedge clk);
    endtask

    task automatic do_sw_rst();
        sw_rst = 1'b1;
        run_cycle();
        sw_rst = 1'b0;
        check("swrst_busy", 64'(busy), 64'(0));
        check("swrst_res_val", 64'(req_res_val), 64'(0));
        check("swrst_orphan", 64'(err_orphan), 64'(0));
    endtask

    initial begin : main
        logic [RESW-1:0] r0;
        int              cycles;
        bit              mid_done;
        bit              seen2;
        n_cmp = 0; n_fail = 0; total_acc = 0;
        rst_n = 1'b0; sw_rst = 1'b0;
        req_op_val = '0; req_op_data = '0; req_res_rdy = '0;
        mult_op_rdy = 1'b1; mult_res_val = 1'b0; mult_res_data = '0;
        stub_data = '0; prev_op_data = '0;
        auto_req = 1'b0; p_new = 0; p_op_rdy = 100; p_res_rdy = 100; p_res_val = 100;
        for (int r = 0; r < NR; r++) begin rq_pend[r] = 1'b0; rq_data[r] = '0; end
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_op_rdy", 64'(req_op_rdy), 64'(0));
        check("rst_res_val", 64'(req_res_val), 64'(0));
        check("rst_op_val", 64'(mult_op_val), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_orphan", 64'(err_orphan), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester: (2+3i)*(4+2i) = 2+16i.
        arm(0, {8'd2, 8'd3, 8'd4, 8'd2});
        repeat (6) run_cycle();
        check("t1_deliveries", 64'(deliv_idx.size()), 64'(1));
        if (deliv_idx.size() > 0) begin
            r0 = deliv_res[0];
            check("t1_idx", 64'(deliv_idx[0]), 64'(0));
            check("t1_xr", 64'(r0[RESW-1 -: CW]), 64'(2));
            check("t1_yr", 64'(r0[CW-1:0]), 64'(16));
        end
        check("t1_busy", 64'(busy), 64'(0));

        // All requesters held valid: grants rotate 0,1,2,3,...
        do_sw_rst();
        grant_log.delete(); deliv_idx.delete(); deliv_res.delete();
        for (int r = 0; r < NR; r++) arm(r, {8'(r + 1), 8'd3, 8'd4, 8'd2});
        auto_req = 1'b1; p_new = 100;
        repeat (10) run_cycle();
        auto_req = 1'b0;
        repeat (10) run_cycle();
        check("rr_count", 64'(grant_log.size() >= 8), 64'(1));
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check("rr_order", 64'(grant_log[i]), 64'(i % NR));
        seen2 = 1'b0;
        for (int j = 0; j < deliv_idx.size(); j++) begin
            if (!seen2 && deliv_idx[j] == 2) begin
                seen2 = 1'b1;
                check("rr_req2_result", 64'(deliv_res[j]), 64'({CW'(6), CW'(18)}));
            end
        end
        check("rr_req2_seen", 64'(seen2), 64'(1));

        // Stall with req 1 and 3 valid; req 0 joins mid-stall.
        do_sw_rst();
        grant_log.delete();
        arm(1, OPW'($urandom));
        arm(3, OPW'($urandom));
        p_op_rdy = 0;
        repeat (2) run_cycle();
        arm(0, OPW'($urandom));
        repeat (3) run_cycle();
        check("lock_data", 64'(mult_op_data), 64'(rq_data[1]));
        check("lock_no_accept", 64'(grant_log.size()), 64'(0));
        p_op_rdy = 100;
        repeat (6) run_cycle();
        check("lock_count", 64'(grant_log.size()), 64'(3));
        if (grant_log.size() == 3) begin
            check("lock_first", 64'(grant_log[0]), 64'(1));
            check("lock_second", 64'(grant_log[1]), 64'(3));
            check("lock_third", 64'(grant_log[2]), 64'(0));
        end

        // Result back-pressure fills the tag FIFO.
        do_sw_rst();
        grant_log.delete();
        p_res_rdy = 0; auto_req = 1'b1; p_new = 100;
        repeat (10) run_cycle();
        check("bp_accepts", 64'(grant_log.size()), 64'(TD));
        check("bp_busy", 64'(busy), 64'(1));
        check("bp_mult_res_rdy", 64'(mult_res_rdy), 64'(0));
        check("bp_op_rdy", 64'(req_op_rdy), 64'(0));
        p_res_rdy = 100; auto_req = 1'b0;
        repeat (20) run_cycle();
        check("bp_resume", 64'(grant_log.size() > TD), 64'(1));
        check("bp_drained", 64'(busy), 64'(0));

        // Orphan result with nothing outstanding.
        do_sw_rst();
        p_res_rdy = 0;
        stub_val = 1'b1; stub_orphan = 1'b1; stub_data = RESW'($urandom);
        run_cycle();
        repeat (2) run_cycle();
        check("orphan_sticky", 64'(err_orphan), 64'(1));
        do_sw_rst();

        // Random traffic with a mid-stream soft reset.
        p_res_rdy = 60; p_op_rdy = 70; p_res_val = 60; p_new = 30; auto_req = 1'b1;
        total_acc = 0; cycles = 0; mid_done = 1'b0;
        while (total_acc < N_OPS && cycles < 30000) begin
            run_cycle();
            cycles++;
            if (!mid_done && total_acc >= N_OPS / 2) begin
                mid_done = 1'b1;
                do_sw_rst();
            end
        end
        check("rand_budget", 64'(total_acc >= N_OPS), 64'(1));
        auto_req = 1'b0; p_res_rdy = 100; p_op_rdy = 100; p_res_val = 100;
        repeat (40) run_cycle();
        check("rand_drained", 64'(busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/comp_mult_arbiter.md
Name: comp_mult_arbiter

Overview:
- Shares one complex-multiplier instance (`comp_mult_wrapper`, any NO_MULT) between NO_REQ independent requesters.
- Each requester has its own operand and result interfaces.
- Operand requests are arbitrated round-robin.
- The requester index of every accepted operation is queued in order. Each multiplier result is returned only to the requester that issued it.
- Sits between the client blocks and `comp_mult_wrapper`. All interfaces are valid/ready.

Parameters:
- DWIDTH, 8, operand component width; multiplier result component width is DWIDTH+1.
- NO_REQ, 4, number of requesters (2..8).
- TAG_DEPTH, 4, maximum operations outstanding inside the multiplier (power of 2, ≥2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  hw reset
- sw_rst  in  1  sw sync reset, active high
- req_op_val  in  NO_REQ  per-requester operands valid
- req_op_rdy  out  NO_REQ  per-requester operands ready
- req_op_data  in  NO_REQ*4*DWIDTH  packed {x1,y1,x2,y2} per requester; requester i at slice i
- req_res_val  out  NO_REQ  per-requester result valid
- req_res_rdy  in  NO_REQ  per-requester result ready
- req_res_data  out  4*(DWIDTH+1)  result {xr,yr}, broadcast to all requesters
- mult_op_val  out  1  to multiplier op_val
- mult_op_rdy  in  1  from multiplier op_rdy
- mult_op_data  out  4*DWIDTH  to multiplier op_data
- mult_res_val  in  1  from multiplier res_val
- mult_res_rdy  out  1  to multiplier res_rdy
- mult_res_data  in  4*(DWIDTH+1)  from multiplier res_data
- busy  out  1  at least one operation outstanding
- err_orphan  out  1  sticky: a result arrived with no outstanding tag

Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low. sw_rst is an additional synchronous clear.

Behaviour:
- Reset values:
  - rst_n low, or sw_rst high at a clock edge: tag FIFO empty, rr pointer = NO_REQ-1, lock = 0, locked grant = 0, err_orphan = 0.
  - Outputs then read: req_op_rdy = 0, req_res_val = 0, mult_op_val = 0, busy = 0.
- Arbitration:
  - Combinational grant.
  - If lock = 0: grant = first index with req_op_val set, searching cyclically from rr pointer+1.
  - If lock = 1: grant = locked index.
- Operand path (zero added latency):
  - mult_op_val = (any req_op_val) & ~tag_full.
  - mult_op_data = req_op_data slice of the granted index.
  - req_op_rdy[g] = mult_op_rdy & ~tag_full for the granted index g; all other bits are 0.
- Grant lock:
  - If mult_op_val=1 and mult_op_rdy=0, lock ← 1 and the grant index is stored. This keeps the mult data stable until accepted.
  - Lock clears on the accepting handshake.
  - Requesters must hold valid/data while waiting; a requester that drops valid while locked is a protocol violation and is not handled.
- Operand accept (mult_op_val & mult_op_rdy):
  - Push grant index into the tag FIFO.
  - rr pointer ← grant index.
- Result path (zero added latency):
  - head = tag FIFO head.
  - req_res_val[head] = mult_res_val & ~tag_empty; other bits are 0.
  - mult_res_rdy = req_res_rdy[head] when the FIFO is not empty.
  - On handshake, pop the FIFO.
- Orphan result (mult_res_val=1, FIFO empty):
  - mult_res_rdy = 1, so the result is consumed and dropped.
  - err_orphan ← 1, cleared only by reset or sw_rst.
- Full / empty:
  - tag_full = (count == TAG_DEPTH), from the registered count. A pop in the same cycle does not allow a push.
  - busy = (count != 0).
- Simultaneous push and pop when not full: count unchanged, both pointers advance. Pointers wrap modulo TAG_DEPTH.
- Reset mid-operation: outstanding tags are discarded. Later results from the multiplier are orphans and set err_orphan. The integrator must reset the multiplier together with this block.
- Ordering and fairness:
  - Results are returned in multiplier output order. `comp_mult_wrapper` is in-order.
  - A requester with valid held high is granted within NO_REQ accepts.

Decomposition:
- Shared include/package:
  - OP_W = 4*DWIDTH, RES_W = 4*(DWIDTH+1), IDX_W = clog2(NO_REQ).
  - Slice helper function for packed requester data.
- Sub-module `comp_mult_tag_fifo`:
  - Sync FIFO, width IDX_W, depth TAG_DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Same reset scheme as this block.
- Arbiter logic and routing stay in the top module.

Test Plan:
- Single requester 0 sends (2+3i)×(4+2i) = {2,3,4,2} → only req_res_val[0] rises; req_res_data decodes xr = 2, yr = 16; busy returns to 0.
- Requesters 0..3 all hold valid continuously with distinct data → grants go 0,1,2,3,0,…; each result reaches its issuer (e.g. req 2 with {3,3,4,2} gets 6+18i).
- mult_op_rdy held 0 for 5 cycles while req 1 and 3 are valid → mult_op_data stays equal to req 1's slice until accept; req 3 is accepted next.
- Multiplier stub returns results with req_res_rdy[head] = 0 for 10 cycles → mult_res_rdy = 0, no pop; after TAG_DEPTH=4 accepts, all req_op_rdy = 0 until one result drains.
- Stub drives mult_res_val = 1 with FIFO empty → handshake completes, err_orphan = 1 and stays set until sw_rst pulse → 0.
- 1000 random ops from 4 requesters with random ready → scoreboard checks per-requester order and values against the complex product, with valid/ready checkers on all interfaces; sw_rst asserted mid-stream → all outputs at reset values next cycle.
